// File: rtl/imem_port_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the shared memory.
//   slave  : arbiter view (requests and memory status in; ready, response and memory drive out)
//   master : requester/memory-model view (the mirror image)
// Signal names keep the arbiter-side i_/o_ prefixes in both views.
interface imem_port_arbiter_if #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = 64
);
   logic [1:0]            i_req_valid;
   logic [1:0]            i_req_we;
   logic [ADDR_WIDTH-1:0] i_req_addr_0;
   logic [ADDR_WIDTH-1:0] i_req_addr_1;
   logic [DATA_WIDTH-1:0] i_req_data_0;
   logic [DATA_WIDTH-1:0] i_req_data_1;
   logic [1:0]            o_req_ready;
   logic [1:0]            o_resp_valid;
   logic [DATA_WIDTH-1:0] o_resp_data;
   logic                  o_resp_err;
   logic [ADDR_WIDTH-1:0] o_mem_addr;
   logic [DATA_WIDTH-1:0] o_mem_data;
   logic                  o_mem_we;
   logic [DATA_WIDTH-1:0] i_mem_read_data;
   logic                  i_mem_access_done;

   modport slave (
      input  i_req_valid, i_req_we, i_req_addr_0, i_req_addr_1, i_req_data_0, i_req_data_1,
      input  i_mem_read_data, i_mem_access_done,
      output o_req_ready, o_resp_valid, o_resp_data, o_resp_err,
      output o_mem_addr, o_mem_data, o_mem_we
   );

   modport master (
      output i_req_valid, i_req_we, i_req_addr_0, i_req_addr_1, i_req_data_0, i_req_data_1,
      output i_mem_read_data, i_mem_access_done,
      input  o_req_ready, o_resp_valid, o_resp_data, o_resp_err,
      input  o_mem_addr, o_mem_data, o_mem_we
   );
endinterface

// File: rtl/imem_port_arbiter.sv
// Two-port round-robin arbiter/sequencer for a shared single-port multi-cycle memory.
// Port 0 is instruction fetch, port 1 is data load/store. One request is captured in IDLE,
// driven to memory from holding registers during ACCESS until done (or timeout), then a
// one-cycle registered response is returned to the winner in RESP.
// Ports:
//   i_clk  : clock, rising edge
//   i_arst : synchronous active-high reset
//   bus    : slave view of imem_port_arbiter_if (requests, ready, response, memory drive)
module imem_port_arbiter #(
   parameter int unsigned DATA_WIDTH     = 32,
   parameter int unsigned ADDR_WIDTH     = 64,
   parameter int unsigned TIMEOUT_CYCLES = 64
) (
   input logic                 i_clk,
   input logic                 i_arst,
   imem_port_arbiter_if.slave  bus
);

   localparam int unsigned CntW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

   state_e                state_q, state_d;
   logic [CntW-1:0]       cnt_q, cnt_d;
   // last_grant also identifies the port owning the transaction in flight.
   logic                  last_grant_q, last_grant_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [DATA_WIDTH-1:0] data_q, data_d;
   logic                  we_q, we_d;
   logic [1:0]            resp_valid_q, resp_valid_d;
   logic [DATA_WIDTH-1:0] resp_data_q, resp_data_d;
   logic                  resp_err_q, resp_err_d;

   logic                  grant_idx;
   logic [1:0]            ready;

   // On a tie the port that did not win last time is chosen.
   always_comb begin
      grant_idx = 1'b0;
      if (bus.i_req_valid == 2'b10) begin
         grant_idx = 1'b1;
      end else if (bus.i_req_valid == 2'b11) begin
         grant_idx = ~last_grant_q;
      end
   end

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      last_grant_d = last_grant_q;
      addr_d       = addr_q;
      data_d       = data_q;
      we_d         = we_q;
      resp_valid_d = 2'b00;
      resp_data_d  = resp_data_q;
      resp_err_d   = resp_err_q;
      ready        = 2'b00;

      case (state_q)
         StIdle: begin
            if (|bus.i_req_valid) begin
               ready[grant_idx] = 1'b1;
               last_grant_d     = grant_idx;
               addr_d           = grant_idx ? bus.i_req_addr_1 : bus.i_req_addr_0;
               data_d           = grant_idx ? bus.i_req_data_1 : bus.i_req_data_0;
               we_d             = bus.i_req_we[grant_idx];
               cnt_d            = '0;
               state_d          = StAccess;
            end
         end
         StAccess: begin
            cnt_d = cnt_q + 1'b1;
            // Done takes priority over a coincident timeout.
            if (bus.i_mem_access_done) begin
               resp_valid_d = {last_grant_q, ~last_grant_q};
               resp_data_d  = we_q ? '0 : bus.i_mem_read_data;
               resp_err_d   = 1'b0;
               state_d      = StResp;
            end else if (cnt_q == CntLast) begin
               resp_valid_d = {last_grant_q, ~last_grant_q};
               resp_data_d  = '0;
               resp_err_d   = 1'b1;
               state_d      = StResp;
            end
         end
         StResp: begin
            cnt_d   = '0;
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_arst) begin
         state_q      <= StIdle;
         cnt_q        <= '0;
         last_grant_q <= 1'b1;
         addr_q       <= '0;
         data_q       <= '0;
         we_q         <= 1'b0;
         resp_valid_q <= 2'b00;
         resp_data_q  <= '0;
         resp_err_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         last_grant_q <= last_grant_d;
         addr_q       <= addr_d;
         data_q       <= data_d;
         we_q         <= we_d;
         resp_valid_q <= resp_valid_d;
         resp_data_q  <= resp_data_d;
         resp_err_q   <= resp_err_d;
      end
   end

   assign bus.o_req_ready  = ready;
   assign bus.o_resp_valid = resp_valid_q;
   assign bus.o_resp_data  = resp_data_q;
   assign bus.o_resp_err   = resp_err_q;
   assign bus.o_mem_addr   = addr_q;
   assign bus.o_mem_data   = data_q;
   assign bus.o_mem_we     = (state_q == StAccess) && we_q;

endmodule
